// File: rtl/tt_um_serial_sub4_if.sv
// Tiny Tapeout pin bundle for the serial subtractor tile.
// The slave side is the tile; the master side is whatever drives the pads.
interface tt_um_serial_sub4_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (
    output ui_in,
    output uio_in,
    output ena,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    input  ena,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_serial_sub4.sv
// Bit-serial 4-bit subtractor: recovers B = {C4,S} - A one bit per clock, LSB first,
// under a start/busy/done handshake, and flags differences no 4-bit B could produce.
module tt_um_serial_sub4 (
  input  logic                clk,
  input  logic                rst,
  tt_um_serial_sub4_if.slave  tt_io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  m_q, m_d;
  logic [4:0]  a_q, a_d;
  logic [4:0]  diff_q, diff_d;
  logic        borrow_q, borrow_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  b_q, b_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start_s;
  logic        last_s;
  logic        load_s;
  logic        shift_s;
  logic        finish_s;
  logic        d_bit_s;
  logic        borrow_nx_s;
  logic        unused_s;

  assign start_s     = tt_io.uio_in[1];
  assign last_s      = (cnt_q == 3'd4);
  assign d_bit_s     = m_q[0] ^ a_q[0] ^ borrow_q;
  assign borrow_nx_s = (~m_q[0] & a_q[0]) | (~(m_q[0] ^ a_q[0]) & borrow_q);
  assign unused_s    = &{1'b0, tt_io.ena, tt_io.uio_in[7:2]};

  // State register, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= 5'd0;
      a_q      <= 5'd0;
      diff_q   <= 5'd0;
      borrow_q <= 1'b0;
      cnt_q    <= 3'd0;
      b_q      <= 4'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      a_q      <= a_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_s) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/control decode; busy/done are registered from the next state
  always_comb begin
    load_s   = 1'b0;
    shift_s  = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) load_s = 1'b1;
        else         load_s = 1'b0;
      end
      ST_RUN: begin
        shift_s = 1'b1;
        if (last_s) finish_s = 1'b1;
        else        finish_s = 1'b0;
      end
      ST_DONE: begin
        if (start_s) load_s = 1'b1;
        else         load_s = 1'b0;
      end
      default: begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Shift datapath; the result register fills from the MSB so bit 0 lands last at D[0]
  always_comb begin
    m_d      = m_q;
    a_d      = a_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    err_d    = err_q;
    if (load_s) begin
      m_d      = {tt_io.uio_in[0], tt_io.ui_in[7:4]};
      a_d      = {1'b0, tt_io.ui_in[3:0]};
      diff_d   = 5'd0;
      borrow_d = 1'b0;
      cnt_d    = 3'd0;
    end else if (shift_s) begin
      m_d      = {1'b0, m_q[4:1]};
      a_d      = {1'b0, a_q[4:1]};
      diff_d   = {d_bit_s, diff_q[4:1]};
      borrow_d = borrow_nx_s;
      cnt_d    = cnt_q + 3'd1;
    end else begin
      cnt_d    = cnt_q;
    end
    // On the fifth bit, diff_q[4:1] is the low nibble of the completed difference
    if (finish_s) begin
      b_d   = diff_q[4:1];
      err_d = borrow_nx_s | d_bit_s;
    end else begin
      b_d   = b_q;
      err_d = err_q;
    end
  end

  assign tt_io.uo_out  = {1'b0, err_q, done_q, busy_q, b_q};
  assign tt_io.uio_out = 8'h00;
  assign tt_io.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_serial_sub4.sv
// Directed and randomized checks of the serial subtractor against an arithmetic model.
module tb_tt_um_serial_sub4;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tt_um_serial_sub4_if dut_if ();

  tt_um_serial_sub4 dut (
    .clk   (clk),
    .rst   (rst),
    .tt_io (dut_if.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Expected uo_out in the DONE cycle: busy=0, done=1
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] s, input logic c4);
    int m, diff;
    logic [3:0] b;
    logic e;
    m    = (c4 ? 16 : 0) + int'(s);
    diff = m - int'(a);
    b    = 4'((diff % 16 + 16) % 16);
    e    = (diff < 0) || (diff > 15);
    return {1'b0, e, 1'b1, 1'b0, b};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] s, input logic c4, input logic st);
    dut_if.ui_in  = {s, a};
    dut_if.uio_in = {6'b000000, st, c4};
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (dut_if.uo_out[5] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] s, input logic c4, input string tag);
    int n;
    @(negedge clk);
    drive(a, s, c4, 1'b1);
    @(negedge clk);
    drive(a, s, c4, 1'b0);
    check({tag, "_busy"}, {7'd0, dut_if.uo_out[4]}, 8'd1);
    wait_done(n);
    check({tag, "_lat"}, 8'(n), 8'd5);
    check({tag, "_res"}, dut_if.uo_out, model(a, s, c4));
  endtask

  initial begin
    int n;
    int dones;
    logic [7:0] seen;
    logic [7:0] exp;
    logic [3:0] ra, rs;
    logic rc;

    dut_if.ena = 1'b1;
    rst = 1'b1;
    drive(4'd5, 4'd12, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("reset_out", dut_if.uo_out, 8'h00);
    rst = 1'b0;
    drive(4'd5, 4'd12, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out", dut_if.uo_out, 8'h00);
    end

    run_op(4'd5, 4'd12, 1'b0, "nominal");
    check("nominal_lit", dut_if.uo_out, 8'h27);
    @(negedge clk);
    check("nominal_hold", dut_if.uo_out, 8'h07);

    // Carry case, then a second op accepted in the DONE cycle
    @(negedge clk);
    drive(4'd9, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(4'd9, 4'd3, 1'b1, 1'b0);
    wait_done(n);
    check("carry_lat", 8'(n), 8'd5);
    check("carry_res", dut_if.uo_out, 8'h2A);
    drive(4'd15, 4'd14, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_accept", dut_if.uo_out, 8'h1A);
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    wait_done(n);
    check("b2b_lat", 8'(n + 1), 8'd6);
    check("b2b_res", dut_if.uo_out, 8'h2F);

    run_op(4'd6, 4'd2, 1'b0, "borrow");
    check("borrow_lit", dut_if.uo_out, 8'h6C);
    run_op(4'd0, 4'd15, 1'b1, "over15");
    check("over15_lit", dut_if.uo_out, 8'h6F);

    // Operands scrambled during RUN and a stray start at edge 2
    @(negedge clk);
    ra = 4'($urandom); rs = 4'($urandom); rc = 1'($urandom);
    exp = model(ra, rs, rc);
    drive(ra, rs, rc, 1'b1);
    dones = 0;
    seen  = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(4'($urandom), 4'($urandom), 1'($urandom), (i == 1));
      if (dut_if.uo_out[5] === 1'b1) begin
        dones++;
        seen = dut_if.uo_out;
      end
    end
    check("ignored_dones", 8'(dones), 8'd1);
    check("ignored_res", seen, exp);

    // Reset sampled at edge 3 of RUN
    @(negedge clk);
    drive(4'd7, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(4'd7, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", dut_if.uo_out, 8'h00);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut_if.uo_out[5] === 1'b1) dones++;
    end
    check("midrst_nodone", 8'(dones), 8'd0);
    run_op(4'd3, 4'd8, 1'b0, "after_rst");
    check("after_rst_lit", dut_if.uo_out, 8'h25);

    // start held high: a new operation at every DONE edge
    @(negedge clk);
    ra = 4'($urandom); rs = 4'($urandom); rc = 1'($urandom);
    exp = model(ra, rs, rc);
    drive(ra, rs, rc, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wait_done(n);
      check("cont_lat", 8'(n + 1), 8'd6);
      check("cont_res", dut_if.uo_out, exp);
      ra = 4'($urandom); rs = 4'($urandom); rc = 1'($urandom);
      exp = model(ra, rs, rc);
      drive(ra, rs, rc, 1'b1);
    end
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int m = 0; m < 32; m++) begin
        run_op(4'(a), 4'(m % 16), 1'(m / 16), "sweep");
      end
    end

    for (int k = 0; k < 30; k++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_serial_sub4.md
# tt_um_serial_sub4

Bit-serial 4-bit subtractor that reverses the team's 4-bit adder tile. Given one operand A and the adder's 5-bit result {C4,S}, it recovers the other operand B = {C4,S} − A, one bit per clock, under a start/busy/done handshake. It flags results that no 4-bit B could have produced. It uses the standard Tiny Tapeout top-level pinout, so it can be hardened as its own tile or chained off the adder tile's outputs.

## Interface
- No parameters. Width is fixed at 4-bit operands and a 5-bit internal difference.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- ui_in  input  8  [3:0] = A, [7:4] = S (adder sum bits)
- uio_in  input  8  [0] = C4 (adder carry-out), [1] = start, [7:2] unused
- uo_out  output  8  [3:0] = B result, [4] = busy, [5] = done, [6] = err, [7] = 0
- uio_out  output  8  constant 0
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs)
- ena  input  1  ignored

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at an edge:
  - load minuend M = {C4,S[3:0]} (5 bits) into a shift register;
  - load A zero-extended to 5 bits into a second shift register;
  - clear borrow, bit counter, and the result shift register;
  - go to RUN.
- RUN, once per edge, LSB first:
  - d = m0 ^ a0 ^ borrow;
  - borrow = (~m0 & a0) | (~(m0 ^ a0) & borrow);
  - shift d into the result register; counter increments.
- After the 5th bit (counter = 4 processed):
  - go to DONE;
  - latch B = D[3:0] and err = borrow_out | D[4] into the output registers.
- DONE lasts exactly one cycle, then returns to IDLE unless start=1 is accepted at that edge.
- start is ignored while busy. Operands are sampled only at the accepting edge; changes to ui_in/uio_in during RUN have no effect.
- err = 1 when {C4,S} < A (borrow out), or when the difference exceeds 15 (D[4]=1).
- When err = 1, B still shows D[3:0], the low nibble of the two's-complement difference.
- uo_out[3:0] and err hold their last values through IDLE and RUN. They change only on the DONE transition or on reset.
- Reset, from any state including mid-RUN:
  - go to IDLE and clear all shift registers, counter, and borrow;
  - B = 0, busy = 0, done = 0, err = 0;
  - uo_out = 0x00 after the reset edge;
  - a partially computed result is discarded and never output.
- rst has priority over start at the same edge.

## Timing
- Edge 0 accepts start. busy = 1 from edge 0 until edge 5.
- Edges 1–5 process bits 0–4.
- After edge 5: busy = 0, done = 1, and B/err are valid.
- After edge 6: done = 0.
- Latency from start acceptance to done: 5 cycles.
- start high during the cycle before edge 5 is ignored, because busy is still 1 at that edge.
- start high during the DONE cycle is accepted at edge 6:
  - busy rises and done falls at that same edge;
  - back-to-back throughput is one operation per 6 cycles.
- start held high continuously: a new operation begins at every DONE edge.
- done is a single-cycle pulse per operation. It never asserts without a preceding accepted start.
- All outputs are registered. There are no combinational paths from inputs to uo_out.

## Test plan
- Reset then idle: assert rst 2 cycles with start=1 -> uo_out = 0x00; busy stays 0 for 10 cycles after rst deasserts with start=0.
- Nominal: A=5, S=12, C4=0, start pulse -> done after exactly 5 cycles, B=7, err=0, uo_out=0x27; B/err hold after done falls.
- Carry case and back-to-back:
  - A=9, S=3, C4=1 (sum 19) -> B=10, err=0;
  - then start held through DONE with A=15, S=14, C4=1 (sum 30) -> second done 6 cycles later, B=15, err=0.
- Error flags:
  - A=6, S=2, C4=0 -> B=12, err=1 (borrow);
  - A=0, S=15, C4=1 (sum 31) -> B=15, err=1 (D[4]).
- Ignored inputs: change A and S every cycle and pulse start at edge 2 while busy -> result matches the operands captured at edge 0; exactly one done pulse.
- Reset mid-operation: assert rst at edge 3 of RUN -> uo_out = 0x00 after that edge and no done pulse. A fresh start afterwards gives a correct result (A=3, S=8, C4=0 -> B=5).
- Exhaustive sweep: all 16×32 combinations of A and {C4,S}, compared against the reference model B = (M−A) mod 16, err = (M<A) | (M−A>15).
